// File: rtl/jpeg_block_sequencer_if.sv
// Control and BRAM-read bus of the JPEG 8x8 block sequencer.
// The master side is the top-level control; the slave side is the sequencer.
interface jpeg_block_sequencer_if #(
    parameter int unsigned BLK_W = 8
);
    logic             start;
    logic [BLK_W-1:0] num_blocks;
    logic             stall;
    logic             busy;
    logic             done;
    logic             rd_en;
    logic [5:0]       addr_input;
    logic [5:0]       addr_quant;
    logic             sample_valid;
    logic [5:0]       sample_idx;
    logic [BLK_W-1:0] block_idx;

    modport master (
        output start, num_blocks, stall,
        input  busy, done, rd_en, addr_input, addr_quant,
        input  sample_valid, sample_idx, block_idx
    );

    modport slave (
        input  start, num_blocks, stall,
        output busy, done, rd_en, addr_input, addr_quant,
        output sample_valid, sample_idx, block_idx
    );
endinterface

// File: rtl/jpeg_block_sequencer.sv
// Walks the input-sample and quant-table BRAMs for N 64-sample blocks and tags
// every returning sample with its index and block number after BRAM_LAT cycles.
module jpeg_block_sequencer #(
    parameter int unsigned BRAM_LAT   = 2,
    parameter logic [5:0]  QUANT_BASE = 6'd47,
    parameter int unsigned BLK_W      = 8
) (
    input logic                   clk,
    input logic                   rst,
    input logic                   ce,
    jpeg_block_sequencer_if.slave bus
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StFlush = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam int unsigned FlushW = (BRAM_LAT > 1) ? $clog2(BRAM_LAT) : 1;
    localparam logic [FlushW-1:0] FlushLast = FlushW'(BRAM_LAT - 1);

    logic [1:0]        state_q, state_d;
    logic [5:0]        addr_q, addr_d;
    logic [BLK_W-1:0]  blk_q, blk_d;
    logic [BLK_W-1:0]  nblk_q, nblk_d;
    logic [FlushW-1:0] flush_q, flush_d;
    logic              rd_en;
    logic              last_blk;

    // Latency pipe: stage 0 holds the read issued last cycle, the tail is the output.
    logic             pipe_v_q   [BRAM_LAT];
    logic [5:0]       pipe_idx_q [BRAM_LAT];
    logic [BLK_W-1:0] pipe_blk_q [BRAM_LAT];

    assign rd_en    = (state_q == StRun) && ce && !bus.stall;
    assign last_blk = (blk_q == nblk_q - BLK_W'(1));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        blk_d   = blk_q;
        nblk_d  = nblk_q;
        flush_d = flush_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    nblk_d  = bus.num_blocks;
                    blk_d   = '0;
                    addr_d  = '0;
                    state_d = (bus.num_blocks == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (!bus.stall) begin
                    addr_d = addr_q + 6'd1;
                    if (addr_q == 6'd63) begin
                        if (last_blk) begin
                            state_d = StFlush;
                            flush_d = '0;
                        end else begin
                            blk_d = blk_q + BLK_W'(1);
                        end
                    end
                end
            end
            StFlush: begin
                if (flush_q == FlushLast) begin
                    state_d = StDone;
                end else begin
                    flush_d = flush_q + FlushW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
                addr_d  = '0;
                blk_d   = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    // Next-state logic ignores ce; the whole register set simply holds when ce=0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            blk_q   <= '0;
            nblk_q  <= '0;
            flush_q <= '0;
            for (int i = 0; i < BRAM_LAT; i++) begin
                pipe_v_q[i]   <= 1'b0;
                pipe_idx_q[i] <= '0;
                pipe_blk_q[i] <= '0;
            end
        end else if (ce) begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            blk_q         <= blk_d;
            nblk_q        <= nblk_d;
            flush_q       <= flush_d;
            pipe_v_q[0]   <= rd_en;
            pipe_idx_q[0] <= addr_q;
            pipe_blk_q[0] <= blk_q;
            for (int i = 1; i < BRAM_LAT; i++) begin
                pipe_v_q[i]   <= pipe_v_q[i-1];
                pipe_idx_q[i] <= pipe_idx_q[i-1];
                pipe_blk_q[i] <= pipe_blk_q[i-1];
            end
        end
    end

    assign bus.busy         = (state_q != StIdle);
    assign bus.done         = (state_q == StDone) && ce;
    assign bus.rd_en        = rd_en;
    assign bus.addr_input   = addr_q;
    assign bus.addr_quant   = QUANT_BASE + addr_q;
    assign bus.sample_valid = pipe_v_q[BRAM_LAT-1] && ce;
    assign bus.sample_idx   = pipe_idx_q[BRAM_LAT-1];
    assign bus.block_idx    = pipe_blk_q[BRAM_LAT-1];

endmodule
